therm_sampler: RTL and testbench

- Upstream front end for the 8-bit thermometer-to-binary priority encoder.
- Samples raw comparator outputs on a strobe and repairs single-bit bubbles by 3-input majority.
- Forces the result into a legal thermometer code and presents it on a valid/ready output register with backpressure.
- Flags any correction applied and counts samples dropped because the output was stalled.

---
 rtl/therm_sampler.sv | 168 ++++++++++++++++
 tb/tb_therm_sampler.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/therm_sampler.sv
// -----------------------------------------------------------------------------
// therm_sampler
//
// Front end for the 8-bit thermometer-to-binary priority encoder. It captures
// raw comparator outputs on a strobe, repairs single-bit bubbles with a
// 3-input majority vote, and forces the result into a legal thermometer code.
// The corrected word is presented on a valid/ready output register.
//
// Samples that arrive while the output register is stalled are dropped. A
// saturating counter records how many were lost.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset; clears all state and
//                overrides every other input
//   sample_en    capture strobe; cmp_in is sampled on every cycle it is high
//   cmp_in       raw comparator outputs, bit 0 = lowest threshold
//   therm_out    corrected thermometer code (0..01..1)
//   therm_valid  therm_out holds an unconsumed word
//   therm_ready  downstream accepts; a transfer happens on valid && ready
//   bubble_err   qualified by therm_valid; the word differs from its raw
//                sample
//   overrun_cnt  saturating count of samples dropped because of a stall
//
// Pipeline: the capture register (raw_q / s1_valid_q) feeds combinational
// correction logic, which loads the output register. Every output comes
// straight from a flop, so no input reaches an output combinationally.
// -----------------------------------------------------------------------------
module therm_sampler #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sample_en,
  input  logic [WIDTH-1:0] cmp_in,
  output logic [WIDTH-1:0] therm_out,
  output logic             therm_valid,
  input  logic             therm_ready,
  output logic             bubble_err,
  output logic [CNT_W-1:0] overrun_cnt
);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] raw_q,         raw_d;
  logic             s1_valid_q,    s1_valid_d;
  logic [WIDTH-1:0] therm_out_q,   therm_out_d;
  logic             therm_valid_q, therm_valid_d;
  logic             bubble_err_q,  bubble_err_d;
  logic [CNT_W-1:0] overrun_cnt_q, overrun_cnt_d;

  // ---------------------------------------------------------------------------
  // Stage 1: capture
  // ---------------------------------------------------------------------------
  // NOTE: every variable written in an always_comb gets a default value
  // first. Any path that leaves it unassigned would otherwise infer a latch.
  always_comb begin
    raw_d      = raw_q;
    s1_valid_d = sample_en;
    if (sample_en) begin
      raw_d = cmp_in;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: bubble repair and legalisation (combinational on raw_q)
  // ---------------------------------------------------------------------------
  // Pad the raw word with a virtual 1 below bit 0 and a virtual 0 above the
  // top bit. Bit 0 then votes as if the run extends downward, and the top
  // bit votes as if the run ends above it.
  logic [WIDTH+1:0] raw_ext;
  logic [WIDTH-1:0] maj_vec;
  logic [WIDTH-1:0] legal_vec;
  logic             corr_err;

  assign raw_ext = {1'b0, raw_q, 1'b1};

  always_comb begin
    maj_vec = '0;
    for (int i = 0; i < WIDTH; i++) begin
      // raw_ext[i+1] is raw_q[i]; its neighbours sit one position either side.
      maj_vec[i] = (raw_ext[i]   & raw_ext[i+1]) |
                   (raw_ext[i]   & raw_ext[i+2]) |
                   (raw_ext[i+1] & raw_ext[i+2]);
    end
  end

  // Keep only the contiguous run of ones that starts at bit 0. Any ones above
  // the first zero survived the vote but are still out of place, so they are
  // cleared.
  always_comb begin
    logic run;
    run       = 1'b1;
    legal_vec = '0;
    for (int i = 0; i < WIDTH; i++) begin
      run          = run & maj_vec[i];
      legal_vec[i] = run;
    end
  end

  assign corr_err = (legal_vec != raw_q);

  // ---------------------------------------------------------------------------
  // Output register with backpressure and overrun counting
  // ---------------------------------------------------------------------------
  logic out_free;  // the register may take a new word this cycle
  logic load;
  logic drop;
  logic consume_only;

  always_comb begin
    // A word leaving this cycle frees the slot for its replacement, so a
    // consume and a load in the same cycle do not drop anything.
    out_free     = !therm_valid_q || therm_ready;
    load         = s1_valid_q && out_free;
    drop         = s1_valid_q && !out_free;
    consume_only = !s1_valid_q && therm_valid_q && therm_ready;

    therm_out_d   = therm_out_q;
    therm_valid_d = therm_valid_q;
    bubble_err_d  = bubble_err_q;
    overrun_cnt_d = overrun_cnt_q;

    if (load) begin
      therm_out_d   = legal_vec;
      bubble_err_d  = corr_err;
      therm_valid_d = 1'b1;
    end else if (consume_only) begin
      // therm_out and bubble_err keep their last value; only valid drops.
      therm_valid_d = 1'b0;
    end

    if (drop && (overrun_cnt_q != {CNT_W{1'b1}})) begin
      overrun_cnt_d = overrun_cnt_q + CNT_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only. Every flop then
  // samples its pre-edge value, whatever order the statements run in.
  always_ff @(posedge clk) begin
    if (rst) begin
      raw_q         <= '0;
      s1_valid_q    <= 1'b0;
      therm_out_q   <= '0;
      therm_valid_q <= 1'b0;
      bubble_err_q  <= 1'b0;
      overrun_cnt_q <= '0;
    end else begin
      raw_q         <= raw_d;
      s1_valid_q    <= s1_valid_d;
      therm_out_q   <= therm_out_d;
      therm_valid_q <= therm_valid_d;
      bubble_err_q  <= bubble_err_d;
      overrun_cnt_q <= overrun_cnt_d;
    end
  end

  assign therm_out   = therm_out_q;
  assign therm_valid = therm_valid_q;
  assign bubble_err  = bubble_err_q;
  assign overrun_cnt = overrun_cnt_q;

endmodule

// File: tb/tb_therm_sampler.sv
// -----------------------------------------------------------------------------
// tb_therm_sampler
//
// Scoreboard bench for therm_sampler. A reference model runs on the rising
// edge and pushes each word the output register should accept. A monitor on
// the falling edge compares the presented word against the head of the queue
// and pops it on every valid && ready transfer.
//
// The bench computes the correction from the behavioural rules: a majority
// vote by counting ones, then the length of the leading run of ones.
// -----------------------------------------------------------------------------
module tb_therm_sampler;

  localparam int W  = 8;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          sample_en;
  logic [W-1:0]  cmp_in;
  logic [W-1:0]  therm_out;
  logic          therm_valid;
  logic          therm_ready;
  logic          bubble_err;
  logic [CW-1:0] overrun_cnt;

  always #5 clk = ~clk;

  therm_sampler #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk         (clk),
    .rst         (rst),
    .sample_en   (sample_en),
    .cmp_in      (cmp_in),
    .therm_out   (therm_out),
    .therm_valid (therm_valid),
    .therm_ready (therm_ready),
    .bubble_err  (bubble_err),
    .overrun_cnt (overrun_cnt)
  );

  int checks   = 0;
  int failures = 0;
  int xfers    = 0;

  typedef struct packed {
    logic [W-1:0] word;
    logic         err;
  } exp_t;

  exp_t sb_q[$];

  // Reference model state
  bit   m_valid = 1'b0;
  bit   m_s1    = 1'b0;
  exp_t m_s1_word;
  int   m_ovr   = 0;
  bit   m_consumed;
  bit   mon_en  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Majority: a bit is 1 when at least two of itself and its neighbours are 1.
  // Below bit 0 counts as 1 and above the top bit counts as 0. The legal code
  // is then 2^n - 1, where n is the number of leading ones of the voted word.
  function automatic exp_t ref_fix(input logic [W-1:0] raw);
    exp_t         e;
    logic [W-1:0] m;
    int           ones;
    int           n;
    bit           stop;
    for (int i = 0; i < W; i++) begin
      ones = (i == 0) ? 1 : int'(raw[i-1]);
      ones += int'(raw[i]);
      ones += (i == W-1) ? 0 : int'(raw[i+1]);
      m[i] = (ones >= 2);
    end
    n    = 0;
    stop = 1'b0;
    for (int i = 0; i < W; i++) begin
      if (!stop && m[i]) n++;
      else stop = 1'b1;
    end
    e.word = W'((1 << n) - 1);
    e.err  = (e.word != raw);
    return e;
  endfunction

  // Reference model: decides which samples reach the output register.
  always @(posedge clk) begin
    if (rst) begin
      sb_q.delete();
      m_valid = 1'b0;
      m_s1    = 1'b0;
      m_ovr   = 0;
    end else begin
      m_consumed = m_valid && therm_ready;
      if (m_s1) begin
        if (!m_valid || m_consumed) begin
          sb_q.push_back(m_s1_word);
          m_valid = 1'b1;
        end else if (m_ovr < (1 << CW) - 1) begin
          m_ovr++;
        end
      end else if (m_consumed) begin
        m_valid = 1'b0;
      end
      m_s1 = sample_en;
      if (sample_en) m_s1_word = ref_fix(cmp_in);
    end
  end

  // Monitor: compares the presented word every cycle, so a word held under a
  // stall is also checked for stability, and pops it on each transfer.
  always @(negedge clk) begin
    if (mon_en) begin
      check("valid", 32'(therm_valid), 32'(m_valid));
      check("overrun_cnt", 32'(overrun_cnt), m_ovr);
      if (therm_valid) begin
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_word unexpected word 0x%0h with empty scoreboard at %0t", therm_out, $time);
        end else begin
          check("sb_word", 32'(therm_out), 32'(sb_q[0].word));
          check("sb_err", 32'(bubble_err), 32'(sb_q[0].err));
          if (therm_ready) begin
            void'(sb_q.pop_front());
            xfers++;
          end
        end
      end
    end
  end

  // Apply one cycle of inputs. This returns just after the rising edge, so
  // checks made right after it sample the outputs away from the edge.
  task automatic drive(input logic r, input logic e, input logic [W-1:0] c, input logic rdy);
    rst         = r;
    sample_en   = e;
    cmp_in      = c;
    therm_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic send_one(input logic [W-1:0] c, input logic [W-1:0] exp_w, input logic exp_e);
    drive(1'b0, 1'b1, c, 1'b1);
    drive(1'b0, 1'b0, '0, 1'b1);
    check("dir_valid", 32'(therm_valid), 32'd1);
    check("dir_word", 32'(therm_out), 32'(exp_w));
    check("dir_err", 32'(bubble_err), 32'(exp_e));
    drive(1'b0, 1'b0, '0, 1'b1);
  endtask

  logic [W-1:0] stream_words [4] = '{8'h01, 8'h03, 8'h07, 8'h0F};

  initial begin
    logic [W-1:0] c;
    logic         r, e, rdy;
    int           n, idx, x0;

    rst = 1'b1; sample_en = 1'b0; cmp_in = '0; therm_ready = 1'b0;

    // Reset state
    drive(1'b1, 1'b0, '0, 1'b0);
    mon_en = 1'b1;
    check("rst_valid", 32'(therm_valid), 32'd0);
    check("rst_word", 32'(therm_out), 32'd0);
    check("rst_err", 32'(bubble_err), 32'd0);
    check("rst_cnt", 32'(overrun_cnt), 32'd0);

    // Clean code and its latency: valid rises two edges after the strobe.
    drive(1'b0, 1'b1, 8'h0F, 1'b1);
    check("lat_valid_n", 32'(therm_valid), 32'd0);
    drive(1'b0, 1'b0, '0, 1'b1);
    check("clean_valid", 32'(therm_valid), 32'd1);
    check("clean_word", 32'(therm_out), 32'h0F);
    check("clean_err", 32'(bubble_err), 32'd0);
    drive(1'b0, 1'b0, '0, 1'b1);
    check("clean_drop_valid", 32'(therm_valid), 32'd0);
    check("clean_keep_word", 32'(therm_out), 32'h0F);

    // Corrections and extremes
    send_one(8'b0000_1101, 8'h0F, 1'b1);
    send_one(8'b0100_0111, 8'h07, 1'b1);
    send_one(8'b0011_0011, 8'h03, 1'b1);
    send_one(8'h00, 8'h00, 1'b0);
    send_one(8'hFF, 8'hFF, 1'b0);

    // Backpressure: the held word survives a dropped sample.
    drive(1'b0, 1'b1, 8'h01, 1'b0);
    drive(1'b0, 1'b0, '0, 1'b0);
    check("bp_held_valid", 32'(therm_valid), 32'd1);
    drive(1'b0, 1'b1, 8'h3F, 1'b0);
    drive(1'b0, 1'b0, '0, 1'b0);
    check("bp_cnt", 32'(overrun_cnt), 32'd1);
    check("bp_word", 32'(therm_out), 32'h01);
    check("bp_valid", 32'(therm_valid), 32'd1);
    drive(1'b0, 1'b0, '0, 1'b1);
    check("bp_consumed", 32'(therm_valid), 32'd0);
    check("bp_keep_word", 32'(therm_out), 32'h01);

    // Streaming: four back-to-back samples give four back-to-back words.
    drive(1'b1, 1'b0, '0, 1'b1);
    x0 = xfers;
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 1'b1, stream_words[k], 1'b1);
      if (k > 0) begin
        check("stream_valid", 32'(therm_valid), 32'd1);
        check("stream_word", 32'(therm_out), 32'(stream_words[k-1]));
      end
    end
    drive(1'b0, 1'b0, '0, 1'b1);
    check("stream_last", 32'(therm_out), 32'(stream_words[3]));
    drive(1'b0, 1'b0, '0, 1'b1);
    check("stream_end_valid", 32'(therm_valid), 32'd0);
    check("stream_xfers", xfers - x0, 32'd4);
    check("stream_cnt", 32'(overrun_cnt), 32'd0);

    // Saturation: 300 samples against a stalled output.
    for (int k = 0; k < 300; k++) drive(1'b0, 1'b1, W'($urandom), 1'b0);
    drive(1'b0, 1'b0, '0, 1'b0);
    check("sat_cnt", 32'(overrun_cnt), 32'd255);
    drive(1'b0, 1'b0, '0, 1'b1);
    drive(1'b0, 1'b0, '0, 1'b1);

    // Reset while a word is held and another sample is in flight
    drive(1'b0, 1'b1, 8'h07, 1'b1);
    drive(1'b0, 1'b1, 8'h1F, 1'b1);
    check("mid_pre_valid", 32'(therm_valid), 32'd1);
    drive(1'b1, 1'b0, '0, 1'b1);
    check("mid_valid", 32'(therm_valid), 32'd0);
    check("mid_word", 32'(therm_out), 32'd0);
    check("mid_cnt", 32'(overrun_cnt), 32'd0);
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 1'b0, '0, 1'b1);
      check("mid_no_ghost", 32'(therm_valid), 32'd0);
    end

    // Randomised traffic, including occasional resets
    for (int k = 0; k < 600; k++) begin
      r   = ($urandom_range(0, 99) == 0);
      e   = ($urandom_range(0, 9) < 7);
      rdy = ($urandom_range(0, 9) < 6);
      case ($urandom_range(0, 3))
        0: c = W'($urandom);
        1: begin
          n = $urandom_range(0, W);
          c = W'((1 << n) - 1);
        end
        default: begin
          n   = $urandom_range(0, W);
          c   = W'((1 << n) - 1);
          idx = $urandom_range(0, W-1);
          c[idx] = ~c[idx];
        end
      endcase
      drive(r, e, c, rdy);
    end

    // Drain with a bounded wait
    for (int k = 0; k < 10 && (therm_valid || m_s1); k++) drive(1'b0, 1'b0, '0, 1'b1);
    drive(1'b0, 1'b0, '0, 1'b1);
    check("drain_valid", 32'(therm_valid), 32'd0);
    check("drain_sb_empty", sb_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
